// File: rtl/alu_cmd_queue_if.sv
// alu_cmd_queue_if: command-side and result-side handshake bundle for alu_cmd_queue.
// The queue uses the slave modport; whatever feeds commands and takes results
// uses the master modport.
`timescale 1ns/1ps

interface alu_cmd_queue_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic         out_zero;
    logic         out_carry;
    logic [2:0]   out_op;
    logic         out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_carry, out_op, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_carry, out_op, out_err
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: DEPTH-entry command FIFO in front of a combinational alu, with a
// registered valid/ready result stage behind it. The FIFO head drives the alu
// operands; the alu outputs are captured when the head is issued.
// Optional feature: define ALU_CMDQ_STATS_EN to add saturating 16-bit issue,
// carry and error counters (stat_issued, stat_carry, stat_err).
`timescale 1ns/1ps

module alu_cmd_queue #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_cmd_queue_if.slave         bus,
    output logic [2:0]             alu_op,
    output logic [W-1:0]           alu_a,
    output logic [W-1:0]           alu_b,
    input  logic [W-1:0]           alu_y,
    input  logic                   alu_zero,
    input  logic                   alu_carry,
    output logic [$clog2(DEPTH):0] count
`ifdef ALU_CMDQ_STATS_EN
    ,
    output logic [15:0]            stat_issued,
    output logic [15:0]            stat_carry,
    output logic [15:0]            stat_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    out_state_t   state_q;
    out_state_t   state_d;

    logic [2:0]   op_mem [DEPTH];
    logic [W-1:0] a_mem  [DEPTH];
    logic [W-1:0] b_mem  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic issue;
    logic head_err;

    logic [W-1:0] y_q;
    logic         zero_q;
    logic         carry_q;
    logic [2:0]   op_q;
    logic         err_q;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign push       = bus.in_valid & ~fifo_full;
    assign issue      = ~fifo_empty & ((state_q == OUT_EMPTY) | bus.out_ready);

    assign alu_op   = fifo_empty ? 3'b000 : op_mem[rd_ptr];
    assign alu_a    = fifo_empty ? '0     : a_mem[rd_ptr];
    assign alu_b    = fifo_empty ? '0     : b_mem[rd_ptr];
    assign head_err = (alu_op > 3'b100);

    assign count         = count_q;
    assign bus.in_ready  = ~fifo_full;
    assign bus.out_valid = (state_q == OUT_FULL);
    assign bus.out_y     = y_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_carry = carry_q;
    assign bus.out_op    = op_q;
    assign bus.out_err   = err_q;

    // Command storage; validity is tracked by the pointers and count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr] <= bus.in_op;
            a_mem[wr_ptr]  <= bus.in_a;
            b_mem[wr_ptr]  <= bus.in_b;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and issue leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !issue) begin
                count_q <= count_q + CW'(1);
            end else if (issue && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Output stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output stage next state: fill on issue, empty when a result leaves with nothing behind it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: begin
                if (issue) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (bus.out_ready && !issue) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase
    end

    // Result register: captures the alu response to the head command as it is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            op_q    <= 3'b000;
            err_q   <= 1'b0;
        end else if (issue) begin
            y_q     <= alu_y;
            zero_q  <= alu_zero;
            carry_q <= alu_carry;
            op_q    <= alu_op;
            err_q   <= head_err;
        end
    end

`ifdef ALU_CMDQ_STATS_EN
    logic [15:0] stat_issued_q;
    logic [15:0] stat_carry_q;
    logic [15:0] stat_err_q;

    assign stat_issued = stat_issued_q;
    assign stat_carry  = stat_carry_q;
    assign stat_err    = stat_err_q;

    // Saturating event counters, bumped once per issued command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_carry_q  <= '0;
            stat_err_q    <= '0;
        end else if (issue) begin
            if (stat_issued_q != 16'hFFFF) begin
                stat_issued_q <= stat_issued_q + 16'd1;
            end
            if (alu_carry && (stat_carry_q != 16'hFFFF)) begin
                stat_carry_q <= stat_carry_q + 16'd1;
            end
            if (head_err && (stat_err_q != 16'hFFFF)) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
        end
    end
`endif

endmodule
